stdp_synapse: RTL
=================

// Module: stdp_synapse
// PURPOSE
//   Plastic synapse directly upstream of the LIF neuron: converts presynaptic spikes into the
//   neuron's 8-bit input current and adapts its weight by pair-based STDP using the neuron's
//   output spike. Per-side spike traces (counters with prescaled decay) set the update magnitude.
// PARAMETERS
//   W_INIT     64   weight after reset
//   W_MIN      0    weight lower clamp
//   W_MAX      255  weight upper clamp
//   TRACE_MAX  15   trace reload value on a spike (fits TRACE_W)
//   DECAY_DIV  4    cycles per trace decrement tick (>=1)
//   LTP_SHIFT  1    potentiation = trace_pre  >> LTP_SHIFT
//   LTD_SHIFT  2    depression   = trace_post >> LTD_SHIFT
// PORTS
//   clk         in   1  clock
//   rst         in   1  synchronous reset, active-high
//   pre_spike   in   1  presynaptic spike, one-cycle pulse
//   post_spike  in   1  postsynaptic spike from LIF neuron
//   learn_en    in   1  1 = weight updates enabled
//   current     out  8  registered synaptic current to LIF neuron
//   weight      out  8  current synaptic weight
//   trace_pre   out  4  presynaptic trace
//   trace_post  out  4  postsynaptic trace
// BEHAVIOUR
//   Reset (rst=1 at edge): weight=W_INIT, current=0, trace_pre=trace_post=0, prescaler=0.
//     Reset mid-operation discards all traces and learned weight; no pending update survives.
//   Current: current <= pre_spike ? weight : 0. Latency 1 cycle; uses pre-update weight.
//   Prescaler: free-running 0..DECAY_DIV-1; tick asserted when count==DECAY_DIV-1.
//     Not restarted by spikes.
//   Trace (each side, independent): spike -> reload TRACE_MAX (wins over tick);
//     else tick and trace>0 -> trace-1; else hold. Never below 0.
//   Learning (learn_en=1), evaluated on registered (pre-edge) trace values:
//     ltp = post_spike ? (trace_pre  >> LTP_SHIFT) : 0   (causal: pre before post)
//     ltd = pre_spike  ? (trace_post >> LTD_SHIFT) : 0   (anti-causal: post before pre)
//     sum = weight + ltp - ltd in signed 10-bit; weight <= clamp(sum, W_MIN, W_MAX).
//   Coincident pre & post in one cycle: both terms apply using old traces; own-cycle
//     reloads do not contribute (a coincident pair is not counted as causal).
//   learn_en=0: weight held; traces, prescaler and current keep running.
//   No handshake; inputs sampled every cycle; multi-cycle spike levels act as repeated spikes.
// STRUCTURE
//   snn_pkg: WEIGHT_W=8, TRACE_W=4, typedefs weight_t, trace_t; clamp function for weight.
//   Sub-module spike_trace (TRACE_MAX param; ports clk, rst, spike, tick, trace),
//     instantiated twice (pre, post). Prescaler, current register and weight-update
//     datapath live in stdp_synapse.
// TESTING
//   1 reset, pre_spike pulse at t0 -> current=64 at t1, 0 at t2; weight stays 64 (no post).
//   2 pre at t0, post at t1, learn_en=1 -> trace_pre=15 at t1; ltp=7 -> weight=71 at t2.
//   3 post at t0, pre at t1 -> ltd=15>>2=3 -> weight=61 at t2; current at t2 = 64.
//   4 weight driven to 250, repeated pre->post pairs -> saturates at 255, never wraps;
//     repeated post->pre pairs from 2 -> clamps at 0.
//   5 single pre, no further spikes -> trace_pre decrements once per 4 cycles,
//     reaches 0 after 15 ticks and holds; pre during tick cycle reloads to 15.
//   6 coincident pre&post with both traces 0 -> weight unchanged; learn_en=0 with
//     pairing -> weight unchanged; rst asserted mid-pairing -> all outputs to reset values.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared widths, types and the weight clamp used by the spiking-neuron datapath.
package snn_pkg;

    localparam int WEIGHT_W = 8;
    localparam int TRACE_W  = 4;
    localparam int SUM_W    = WEIGHT_W + 2;

    typedef logic [WEIGHT_W-1:0] weight_t;
    typedef logic [TRACE_W-1:0]  trace_t;
    typedef logic signed [SUM_W-1:0] wsum_t;

    // Saturate a signed weight sum into [lo, hi]; the sum never needs wrapping.
    function automatic weight_t clamp_weight(input wsum_t sum, input weight_t lo, input weight_t hi);
        weight_t res;
        if (sum < $signed({2'b00, lo})) begin
            res = lo;
        end else if (sum > $signed({2'b00, hi})) begin
            res = hi;
        end else begin
            res = sum[WEIGHT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/spike_trace.sv
// Spike trace counter: reloads on a spike, decays by one on each prescaler tick.
module spike_trace
    import snn_pkg::*;
#(
    parameter int TRACE_MAX = 15
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   spike,
    input  logic   tick,
    output trace_t trace
);

    trace_t trace_r;

    // Trace register: a spike reload takes priority over a decay tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_r <= {TRACE_W{1'b0}};
        end else if (spike) begin
            trace_r <= TRACE_W'(TRACE_MAX);
        end else if (tick && (trace_r != {TRACE_W{1'b0}})) begin
            trace_r <= trace_r - TRACE_W'(1);
        end else begin
            trace_r <= trace_r;
        end
    end

    assign trace = trace_r;

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: drives the neuron input current and adapts its weight by pair-based STDP.
module stdp_synapse
    import snn_pkg::*;
#(
    parameter int W_INIT    = 64,
    parameter int W_MIN     = 0,
    parameter int W_MAX     = 255,
    parameter int TRACE_MAX = 15,
    parameter int DECAY_DIV = 4,
    parameter int LTP_SHIFT = 1,
    parameter int LTD_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pre_spike,
    input  logic                post_spike,
    input  logic                learn_en,
    output logic [WEIGHT_W-1:0] current,
    output logic [WEIGHT_W-1:0] weight,
    output logic [TRACE_W-1:0]  trace_pre,
    output logic [TRACE_W-1:0]  trace_post
);

    localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    weight_t          weight_r;
    weight_t          current_r;
    weight_t          weight_nxt_s;
    trace_t           trace_pre_s;
    trace_t           trace_post_s;
    trace_t           ltp_s;
    trace_t           ltd_s;
    wsum_t            sum_s;

    assign tick_s = (presc_r == PRE_W'(DECAY_DIV - 1));

    // Free-running decay prescaler, independent of spike activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    spike_trace #(.TRACE_MAX(TRACE_MAX)) u_trace_pre (
        .clk   (clk),
        .rst   (rst),
        .spike (pre_spike),
        .tick  (tick_s),
        .trace (trace_pre_s)
    );

    spike_trace #(.TRACE_MAX(TRACE_MAX)) u_trace_post (
        .clk   (clk),
        .rst   (rst),
        .spike (post_spike),
        .tick  (tick_s),
        .trace (trace_post_s)
    );

    // Weight update from the registered traces, so same-cycle reloads never count as a pair.
    always_comb begin
        ltp_s        = {TRACE_W{1'b0}};
        ltd_s        = {TRACE_W{1'b0}};
        weight_nxt_s = weight_r;
        if (post_spike) begin
            ltp_s = trace_pre_s >> LTP_SHIFT;
        end else begin
            ltp_s = {TRACE_W{1'b0}};
        end
        if (pre_spike) begin
            ltd_s = trace_post_s >> LTD_SHIFT;
        end else begin
            ltd_s = {TRACE_W{1'b0}};
        end
        sum_s = $signed({2'b00, weight_r})
              + $signed({{(SUM_W-TRACE_W){1'b0}}, ltp_s})
              - $signed({{(SUM_W-TRACE_W){1'b0}}, ltd_s});
        if (learn_en) begin
            weight_nxt_s = clamp_weight(sum_s, weight_t'(W_MIN), weight_t'(W_MAX));
        end else begin
            weight_nxt_s = weight_r;
        end
    end

    // Weight and current registers; current uses the weight from before this cycle's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_r  <= weight_t'(W_INIT);
            current_r <= {WEIGHT_W{1'b0}};
        end else begin
            weight_r  <= weight_nxt_s;
            current_r <= pre_spike ? weight_r : {WEIGHT_W{1'b0}};
        end
    end

    assign current    = current_r;
    assign weight     = weight_r;
    assign trace_pre  = trace_pre_s;
    assign trace_post = trace_post_s;

endmodule
